tanh_pwl_stream: RTL and testbench



---
 rtl/tanh_pwl_stream.sv | 174 +++++++++++++++++
 tb/tb_tanh_pwl_stream.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tanh_pwl_stream.sv
// tanh_pwl_stream: 3-stage valid/ready tanh unit (shift-add PWL or hard clip), Q1.(W-1) output.
// Optional macro TANH_PWL_SATCNT_EN compiles in the saturated-delivery counter.
`default_nettype none

module tanh_pwl_stream #(
  parameter int W    = 8,
  parameter int FRAC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_sat,
  input  logic         sat_clr,
  output logic [15:0]  sat_count
);

  localparam int SH = W - 1 - FRAC;
  localparam int IW = W + 3 + SH;
  localparam int F  = W + 2;

  // Thresholds compared against 4*a so that 1.25 stays an integer even when FRAC is 1.
  localparam logic [W+1:0]  c_T05  = (W+2)'(2)  << FRAC;
  localparam logic [W+1:0]  c_T10  = (W+2)'(4)  << FRAC;
  localparam logic [W+1:0]  c_T125 = (W+2)'(5)  << FRAC;
  localparam logic [W+1:0]  c_T25  = (W+2)'(10) << FRAC;
  localparam logic [IW-1:0] c_Q025 = IW'(1)  << (F - 2);
  localparam logic [IW-1:0] c_K    = IW'(23) << (F - 5);
  localparam logic [W-1:0]  c_MAX  = {1'b0, {(W-1){1'b1}}};

  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  logic [W-1:0] w_abs;
  logic [W+1:0] w_a4;
  logic [1:0]   w_seg;

  assign w_abs = in_data[W-1] ? (~in_data + 1'b1) : in_data;
  assign w_a4  = {w_abs, 2'b00};

  // Hard mode reuses the segment field as a single "clip" bit.
  always_comb begin
    w_seg = 2'd3;
    if (in_mode) begin
      w_seg = (w_a4 < c_T10) ? 2'd0 : 2'd1;
    end else if (w_a4 < c_T05) begin
      w_seg = 2'd0;
    end else if (w_a4 < c_T125) begin
      w_seg = 2'd1;
    end else if (w_a4 < c_T25) begin
      w_seg = 2'd2;
    end
  end

  logic         r_s1_v;
  logic         r_s1_neg;
  logic [W-1:0] r_s1_abs;
  logic         r_s1_mode;
  logic [1:0]   r_s1_seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_neg  <= 1'b0;
      r_s1_abs  <= '0;
      r_s1_mode <= 1'b0;
      r_s1_seg  <= 2'd0;
    end else if (w_adv) begin
      r_s1_v    <= in_valid;
      r_s1_neg  <= in_data[W-1];
      r_s1_abs  <= w_abs;
      r_s1_mode <= in_mode;
      r_s1_seg  <= w_seg;
    end
  end

  logic [IW-1:0] w_ax;
  logic [IW-1:0] w_m;
  logic [W-1:0]  w_mtr;
  logic          w_force;

  always_comb begin
    w_ax    = IW'(r_s1_abs) << (SH + 3);
    w_force = r_s1_mode ? r_s1_seg[0] : (r_s1_seg == 2'd3);
    w_m     = w_ax;
    if (!r_s1_mode) begin
      case (r_s1_seg)
        2'd1:    w_m = (w_ax >> 1) + c_Q025;
        2'd2:    w_m = (w_ax >> 3) + c_K;
        2'd3:    w_m = '0;
        default: w_m = w_ax;
      endcase
    end
  end

  // Drop the three guard bits: truncation toward zero on the magnitude.
  assign w_mtr = W'(w_m >> 3);

  logic         r_s2_v;
  logic         r_s2_neg;
  logic [W-1:0] r_s2_mag;
  logic         r_s2_force;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v     <= 1'b0;
      r_s2_neg   <= 1'b0;
      r_s2_mag   <= '0;
      r_s2_force <= 1'b0;
    end else if (w_adv) begin
      r_s2_v     <= r_s1_v;
      r_s2_neg   <= r_s1_neg;
      r_s2_mag   <= w_mtr;
      r_s2_force <= w_force;
    end
  end

  logic         w_sat;
  logic [W-1:0] w_magc;
  logic [W-1:0] w_res;

  assign w_sat  = r_s2_force || (r_s2_mag > c_MAX);
  assign w_magc = w_sat ? c_MAX : r_s2_mag;
  assign w_res  = r_s2_neg ? (~w_magc + 1'b1) : w_magc;

  logic         r_s3_v;
  logic [W-1:0] r_s3_data;
  logic         r_s3_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_v    <= 1'b0;
      r_s3_data <= '0;
      r_s3_sat  <= 1'b0;
    end else if (w_adv) begin
      r_s3_v    <= r_s2_v;
      r_s3_data <= w_res;
      r_s3_sat  <= w_sat;
    end
  end

  assign out_valid = r_s3_v;
  assign out_data  = r_s3_data;
  assign out_sat   = r_s3_sat;

`ifdef TANH_PWL_SATCNT_EN
  logic [15:0] r_sat_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_count <= 16'd0;
    end else if (sat_clr) begin
      r_sat_count <= 16'd0;
    end else if (out_valid && out_ready && out_sat && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end

  assign sat_count = r_sat_count;
`else
  logic w_unused_clr;
  assign w_unused_clr = sat_clr;
  assign sat_count    = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tanh_pwl_stream.sv
// Self-checking bench for tanh_pwl_stream (W=8, FRAC=4): directed table, backpressure, reset, random vs real-valued model.
`default_nettype none

module tb_tanh_pwl_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sat;
  logic        sat_clr;
  logic [15:0] sat_count;

  tanh_pwl_stream #(.W(8), .FRAC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  logic [8:0] exp_q[$];
  int   exp_cnt  = 0;
  int   n_acc    = 0;
  int   n_del    = 0;
  bit   prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic prev_sat;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: plain real arithmetic from the segment definitions.
  function automatic logic [8:0] model(input logic [7:0] d, input logic m);
    int   v;
    int   mi;
    real  a;
    real  mg;
    logic sat;
    logic [7:0] o;
    v   = int'($signed(d));
    a   = (v < 0 ? -v : v) / 16.0;
    sat = 1'b0;
    mg  = 0.0;
    if (!m) begin
      if (a < 0.5)       mg = a;
      else if (a < 1.25) mg = a / 2.0 + 0.25;
      else if (a < 2.5)  mg = a / 8.0 + 0.71875;
      else               sat = 1'b1;
    end else begin
      if (a < 1.0) mg = a;
      else         sat = 1'b1;
    end
    mi = sat ? 127 : $rtoi(mg * 128.0);
    if (mi > 127) begin
      mi  = 127;
      sat = 1'b1;
    end
    o = (v < 0) ? 8'(-mi) : 8'(mi);
    return {sat, o};
  endfunction

  // One clock: observe at the falling edge, then return 1 time unit after the rising edge.
  task automatic tick();
    logic [8:0] e;
    @(negedge clk);
    check("in_ready", in_ready, (!out_valid || out_ready) ? 1 : 0);
    check("sat_count", sat_count, exp_cnt);
    if (prev_stall) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, prev_data);
      check("stall_sat", out_sat, prev_sat);
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_sat   = out_sat;
    if (out_valid && out_ready) begin
      n_del++;
      if (exp_q.size() == 0) begin
        check("extra_beat", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e[7:0]);
        check("out_sat", out_sat, e[8]);
      end
    end
`ifdef TANH_PWL_SATCNT_EN
    if (sat_clr) exp_cnt = 0;
    else if (out_valid && out_ready && out_sat && exp_cnt < 65535) exp_cnt++;
`endif
    if (in_valid && in_ready) begin
      exp_q.push_back(model(in_data, in_mode));
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       m;
    logic [7:0] e;
    logic       s;
  } vec_t;

  vec_t tbl[11];

  task automatic run_dir(input vec_t v, input int idx);
    int lat;
    in_valid  = 1'b1;
    in_data   = v.d;
    in_mode   = v.m;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      tick();
      lat++;
    end
    check($sformatf("dir%0d_latency", idx), lat, 3);
    check($sformatf("dir%0d_data", idx), out_data, v.e);
    check($sformatf("dir%0d_sat", idx), out_sat, v.s);
    tick();
  endtask

  initial begin
    bit pat[4];
    int guard;
    int d0;

    tbl[0]  = '{8'h04, 1'b0, 8'h20, 1'b0};
    tbl[1]  = '{8'h08, 1'b0, 8'h40, 1'b0};
    tbl[2]  = '{8'h10, 1'b0, 8'h60, 1'b0};
    tbl[3]  = '{8'h18, 1'b0, 8'h74, 1'b0};
    tbl[4]  = '{8'h20, 1'b0, 8'h7C, 1'b0};
    tbl[5]  = '{8'hF0, 1'b0, 8'hA0, 1'b0};
    tbl[6]  = '{8'h30, 1'b0, 8'h7F, 1'b1};
    tbl[7]  = '{8'h80, 1'b0, 8'h81, 1'b1};
    tbl[8]  = '{8'h0C, 1'b1, 8'h60, 1'b0};
    tbl[9]  = '{8'h18, 1'b1, 8'h7F, 1'b1};
    tbl[10] = '{8'hE8, 1'b1, 8'h81, 1'b1};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_in_ready", in_ready, 1);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) run_dir(tbl[i], i);

    // Backpressure: 8 back-to-back beats under a 1,0,0,1 ready pattern.
    n_acc = 0;
    d0    = n_del;
    guard = 0;
    while (n_acc < 8 && guard < 200) begin
      out_ready = pat[guard % 4];
      in_valid  = 1'b1;
      in_data   = 8'($urandom);
      in_mode   = 1'($urandom);
      tick();
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("bp_accepted", n_acc, 8);
    check("bp_delivered", n_del - d0, 8);
    check("bp_queue_empty", exp_q.size(), 0);

    // Reset with three beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h30 + 8'(i);
      in_mode  = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_sat", out_sat, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_sat_count", sat_count, 0);
    exp_q.delete();
    exp_cnt    = 0;
    prev_stall = 1'b0;
    out_ready  = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      check("post_rst_no_stale", out_valid, 0);
      tick();
    end

`ifdef TANH_PWL_SATCNT_EN
    // 5 saturated + 3 unsaturated deliveries.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = (i < 5) ? 8'h30 : 8'h04;
      in_mode  = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("cnt_five", sat_count, 5);

    // Clear coinciding with a saturated delivery.
    in_valid = 1'b1;
    in_data  = 8'h80;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 8) begin
      tick();
      guard++;
    end
    check("clr_beat_valid", out_valid, 1);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    check("clr_wins", sat_count, 0);

    // Saturate the counter.
    in_valid = 1'b1;
    in_data  = 8'h7F;
    for (int i = 0; i < 65540; i++) tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("cnt_sticky", sat_count, 16'hFFFF);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    check("cnt_cleared", sat_count, 0);
`else
    in_valid = 1'b1;
    in_data  = 8'h7F;
    sat_clr  = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    in_valid = 1'b0;
    sat_clr  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("cnt_tied_zero", sat_count, 0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_mode   = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      sat_clr   = ($urandom_range(0, 15) == 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("rand_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
